// File: rtl/vga_layer_addr_pipe.sv
// vga_layer_addr_pipe
// Pipelined VGA layer address generator. Each active pixel is looked up in a
// synchronous map RAM, tested against NUM_CHARS double-buffered character
// positions, and turned into registered memory selects, addresses and pixel
// offsets for the RGB decoder. Pac-Man (character 0) versus ghost collisions
// are accumulated per pixel and reported once per frame.
//
// Streaming contract: there is no ready signal. i_pix_valid qualifies
// i_x_cord/i_y_cord in the cycle it is high, every stage advances on every
// clock, and o_valid is i_pix_valid delayed by the pipeline depth. Invalid
// slots travel down the pipeline as all-zero outputs.
module vga_layer_addr_pipe #(
  parameter int NUM_CHARS      = 4,
  parameter int MAP_ROWS       = 36,
  parameter int MAP_COLS       = 28,
  parameter int NUM_TILE_TYPES = 2,
  parameter int MAP_ADDR_W     = 5,
  localparam int IDX_W         = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1,
  localparam int CHAR_ADDR_W   = IDX_W + 2,
  localparam int RADDR_W       = $clog2(MAP_ROWS * MAP_COLS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pix_valid,
  input  logic                   i_show_en,
  input  logic [9:0]             i_x_cord,
  input  logic [9:0]             i_y_cord,
  input  logic                   i_frame_start,
  input  logic                   i_cfg_we,
  input  logic [IDX_W-1:0]       i_cfg_idx,
  input  logic                   i_cfg_en,
  input  logic [9:0]             i_cfg_x,
  input  logic [9:0]             i_cfg_y,
  output logic [RADDR_W-1:0]     o_map_raddr,
  input  logic [7:0]             i_map_rdata,
  output logic                   o_valid,
  output logic [1:0]             o_mem_select,
  output logic [MAP_ADDR_W-1:0]  o_address_map,
  output logic [CHAR_ADDR_W-1:0] o_address_char,
  output logic [5:0]             o_tile_offset,
  output logic [5:0]             o_char_offset,
  output logic [NUM_CHARS-1:0]   o_collision
);

  // Character position registers: shadow is written by software at any time,
  // active is what the pixel pipeline uses and only changes at frame start.
  logic [NUM_CHARS-1:0] sh_en;
  logic [9:0]           sh_x  [NUM_CHARS];
  logic [9:0]           sh_y  [NUM_CHARS];
  logic [NUM_CHARS-1:0] act_en;
  logic [9:0]           act_x [NUM_CHARS];
  logic [9:0]           act_y [NUM_CHARS];

  // Stage 1 registers
  logic       s1_valid;
  logic       s1_show;
  logic       s1_in_map;
  logic [9:0] s1_x;
  logic [9:0] s1_y;

  // Stage 2 registers
  logic                 s2_valid;
  logic                 s2_area;
  logic [2:0]           s2_x3;
  logic [2:0]           s2_y3;
  logic                 s2_hit;
  logic [IDX_W-1:0]     s2_idx;
  logic [1:0]           s2_part;
  logic [5:0]           s2_coff;
  logic [NUM_CHARS-1:0] s2_coll;

  // Collision accumulator for the current frame
  logic [NUM_CHARS-1:0] acc;

  // Input-side map decode
  logic               in_map_in;
  logic [RADDR_W-1:0] raddr_in;

  assign in_map_in = (int'(i_x_cord) < 8 * MAP_ROWS) && (int'(i_y_cord) < 8 * MAP_COLS);
  assign raddr_in  = RADDR_W'(int'(i_x_cord[9:3]) * MAP_COLS + int'(i_y_cord[9:3]));

  // Shadow writes and frame-start commit into the active set; the commit
  // uses pre-edge shadow values, so a write on the commit edge waits a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_en  <= '0;
      act_en <= '0;
      for (int k = 0; k < NUM_CHARS; k++) begin
        sh_x[k]  <= '0;
        sh_y[k]  <= '0;
        act_x[k] <= '0;
        act_y[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CHARS; k++) begin
        if (i_cfg_we && (i_cfg_idx == IDX_W'(k))) begin
          sh_en[k] <= i_cfg_en;
          sh_x[k]  <= i_cfg_x;
          sh_y[k]  <= i_cfg_y;
        end
      end
      if (i_frame_start) begin
        act_en <= sh_en;
        for (int k = 0; k < NUM_CHARS; k++) begin
          act_x[k] <= sh_x[k];
          act_y[k] <= sh_y[k];
        end
      end
    end
  end

  // Stage 1: capture the pixel and issue the map RAM read address
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1_show     <= 1'b0;
      s1_in_map   <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      o_map_raddr <= '0;
    end else begin
      s1_valid    <= i_pix_valid;
      s1_show     <= i_show_en;
      s1_in_map   <= in_map_in;
      s1_x        <= i_x_cord;
      s1_y        <= i_y_cord;
      o_map_raddr <= (i_pix_valid && in_map_in) ? raddr_in : '0;
    end
  end

  // Per-character coverage of the stage-1 pixel. End coordinates are 11 bits
  // wide so a sprite placed near 1023 does not wrap back to 0.
  logic [NUM_CHARS-1:0] cov;
  logic [3:0]           dx [NUM_CHARS];
  logic [3:0]           dy [NUM_CHARS];

  for (genvar k = 0; k < NUM_CHARS; k++) begin : g_cov
    logic [10:0] x_end;
    logic [10:0] y_end;
    assign x_end  = {1'b0, act_x[k]} + 11'd16;
    assign y_end  = {1'b0, act_y[k]} + 11'd16;
    assign cov[k] = act_en[k]
                 && (s1_x >= act_x[k]) && ({1'b0, s1_x} < x_end)
                 && (s1_y >= act_y[k]) && ({1'b0, s1_y} < y_end);
    assign dx[k]  = s1_x[3:0] - act_x[k][3:0];
    assign dy[k]  = s1_y[3:0] - act_y[k][3:0];
  end

  logic                 win_hit;
  logic [IDX_W-1:0]     win_idx;
  logic [1:0]           win_part;
  logic [5:0]           win_off;
  logic [NUM_CHARS-1:0] coll_vec;

  // Priority select: scanning high to low lets the lowest covering index win
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    win_part = '0;
    win_off  = '0;
    for (int k = NUM_CHARS - 1; k >= 0; k--) begin
      if (cov[k]) begin
        win_hit  = 1'b1;
        win_idx  = IDX_W'(k);
        win_part = {dx[k][3], dy[k][3]};
        win_off  = {dx[k][2:0], dy[k][2:0]};
      end
    end
    coll_vec = cov[0] ? (cov & ~NUM_CHARS'(1)) : '0;
  end

  // Stage 2: hold the overlap result while the map RAM data arrives
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_area  <= 1'b0;
      s2_x3    <= '0;
      s2_y3    <= '0;
      s2_hit   <= 1'b0;
      s2_idx   <= '0;
      s2_part  <= '0;
      s2_coff  <= '0;
      s2_coll  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_area  <= s1_valid && s1_show && s1_in_map;
      s2_x3    <= s1_x[2:0];
      s2_y3    <= s1_y[2:0];
      s2_hit   <= win_hit;
      s2_idx   <= win_idx;
      s2_part  <= win_part;
      s2_coff  <= win_off;
      s2_coll  <= coll_vec;
    end
  end

  // Output stage: combine map RAM data with the stage-2 character result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid        <= 1'b0;
      o_mem_select   <= '0;
      o_address_map  <= '0;
      o_address_char <= '0;
      o_tile_offset  <= '0;
      o_char_offset  <= '0;
    end else begin
      o_valid <= s2_valid;
      if (s2_area) begin
        o_mem_select[0] <= 1'b1;
        o_address_map   <= (int'(i_map_rdata) < NUM_TILE_TYPES) ? MAP_ADDR_W'(i_map_rdata) : '0;
        o_tile_offset   <= {s2_x3, s2_y3};
        o_mem_select[1] <= s2_hit;
        o_address_char  <= s2_hit ? {s2_idx, s2_part} : '0;
        o_char_offset   <= s2_hit ? s2_coff : '0;
      end else begin
        o_mem_select   <= '0;
        o_address_map  <= '0;
        o_address_char <= '0;
        o_tile_offset  <= '0;
        o_char_offset  <= '0;
      end
    end
  end

  // Sticky per-frame collision flags; a hit on the frame-start edge is still
  // reported with the frame that is ending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc         <= '0;
      o_collision <= '0;
    end else if (i_frame_start) begin
      o_collision <= acc | (s2_area ? s2_coll : '0);
      acc         <= '0;
    end else begin
      acc <= acc | (s2_area ? s2_coll : '0);
    end
  end

endmodule

// File: tb/tb_vga_layer_addr_pipe.sv
// Directed testbench for vga_layer_addr_pipe with hand-computed expectations.
module tb_vga_layer_addr_pipe;

  localparam int NUM_CHARS   = 4;
  localparam int IDX_W       = 2;
  localparam int CHAR_ADDR_W = 4;
  localparam int RADDR_W     = 10;
  localparam int MAP_ADDR_W  = 5;

  logic                   clk;
  logic                   rst;
  logic                   pix_valid;
  logic                   show_en;
  logic [9:0]             x_cord;
  logic [9:0]             y_cord;
  logic                   frame_start;
  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_idx;
  logic                   cfg_en;
  logic [9:0]             cfg_x;
  logic [9:0]             cfg_y;
  logic [RADDR_W-1:0]     map_raddr;
  logic [7:0]             map_rdata;
  logic                   valid;
  logic [1:0]             mem_select;
  logic [MAP_ADDR_W-1:0]  address_map;
  logic [CHAR_ADDR_W-1:0] address_char;
  logic [5:0]             tile_offset;
  logic [5:0]             char_offset;
  logic [NUM_CHARS-1:0]   collision;

  int n_checks;
  int n_fail;

  vga_layer_addr_pipe dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pix_valid    (pix_valid),
    .i_show_en      (show_en),
    .i_x_cord       (x_cord),
    .i_y_cord       (y_cord),
    .i_frame_start  (frame_start),
    .i_cfg_we       (cfg_we),
    .i_cfg_idx      (cfg_idx),
    .i_cfg_en       (cfg_en),
    .i_cfg_x        (cfg_x),
    .i_cfg_y        (cfg_y),
    .o_map_raddr    (map_raddr),
    .i_map_rdata    (map_rdata),
    .o_valid        (valid),
    .o_mem_select   (mem_select),
    .o_address_map  (address_map),
    .o_address_char (address_char),
    .o_tile_offset  (tile_offset),
    .o_char_offset  (char_offset),
    .o_collision    (collision)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic en, input int x, input int y);
    cfg_we  = 1'b1;
    cfg_idx = IDX_W'(idx);
    cfg_en  = en;
    cfg_x   = 10'(x);
    cfg_y   = 10'(y);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One isolated pixel: checks the read address after the sampling edge,
  // then waits until its results are on the outputs.
  task automatic run_pixel(input string tag, input int x, input int y, input logic show,
                           input int exp_raddr);
    pix_valid = 1'b1;
    show_en   = show;
    x_cord    = 10'(x);
    y_cord    = 10'(y);
    tick();
    pix_valid = 1'b0;
    check({tag, " raddr"}, 32'(map_raddr), 32'(exp_raddr));
    tick();
    tick();
  endtask

  task automatic check_out(input string tag, input logic v, input int sel, input int amap,
                           input int achar, input int toff, input int coff);
    check({tag, " valid"}, 32'(valid), 32'(v));
    check({tag, " sel"},   32'(mem_select), 32'(sel));
    check({tag, " amap"},  32'(address_map), 32'(amap));
    check({tag, " achar"}, 32'(address_char), 32'(achar));
    check({tag, " toff"},  32'(tile_offset), 32'(toff));
    check({tag, " coff"},  32'(char_offset), 32'(coff));
  endtask

  // Stream an n-by-n block starting at the origin, then flush the pipeline
  task automatic stream_block(input int n);
    show_en = 1'b1;
    for (int xi = 0; xi < n; xi++) begin
      for (int yi = 0; yi < n; yi++) begin
        pix_valid = 1'b1;
        x_cord    = 10'(xi);
        y_cord    = 10'(yi);
        tick();
      end
    end
    pix_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    pix_valid   = 1'b0;
    show_en     = 1'b0;
    x_cord      = '0;
    y_cord      = '0;
    frame_start = 1'b0;
    cfg_we      = 1'b0;
    cfg_idx     = '0;
    cfg_en      = 1'b0;
    cfg_x       = '0;
    cfg_y       = '0;
    map_rdata   = 8'd1;

    // Reset, then map path
    tick();
    tick();
    check("rst raddr", 32'(map_raddr), 0);
    check("rst coll",  32'(collision), 0);
    check_out("rst", 1'b0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    run_pixel("map", 9, 17, 1'b1, 30);
    check_out("map", 1'b1, 1, 1, 0, 9, 0);

    // Priority: chars 1 and 2 share a position, index 1 must win
    cfg_write(2, 1'b1, 100, 50);
    cfg_write(1, 1'b1, 100, 50);
    frame_pulse();
    check("prio coll", 32'(collision), 0);
    run_pixel("prio", 109, 61, 1'b1, 13 * 28 + 7);
    check_out("prio", 1'b1, 3, 1, 7, 45, 11);

    // Double buffer: shadow write is invisible until frame start
    cfg_write(0, 1'b1, 40, 40);
    run_pixel("dbuf_pre", 41, 41, 1'b1, 5 * 28 + 5);
    check_out("dbuf_pre", 1'b1, 1, 1, 0, 9, 0);
    frame_pulse();
    run_pixel("dbuf_post", 41, 41, 1'b1, 5 * 28 + 5);
    check_out("dbuf_post", 1'b1, 3, 1, 0, 9, 9);

    // Show disabled: inside the map but nothing is selected
    run_pixel("noshow", 41, 41, 1'b0, 5 * 28 + 5);
    check_out("noshow", 1'b1, 0, 0, 0, 0, 0);

    // Collision: Pac-Man at (0,0), ghost 3 at (8,8)
    cfg_write(0, 1'b1, 0, 0);
    cfg_write(1, 1'b0, 0, 0);
    cfg_write(2, 1'b0, 0, 0);
    cfg_write(3, 1'b1, 8, 8);
    frame_pulse();
    check("coll commit", 32'(collision), 0);
    stream_block(24);
    cfg_write(3, 1'b1, 200, 200);
    frame_pulse();
    check("coll hit", 32'(collision), 32'h8);
    stream_block(24);
    frame_pulse();
    check("coll clear", 32'(collision), 0);

    // Boundary: just outside and just inside the map, unknown tile code
    map_rdata = 8'd7;
    run_pixel("bnd_x", 288, 0, 1'b1, 0);
    check_out("bnd_x", 1'b1, 0, 0, 0, 0, 0);
    run_pixel("bnd_y", 0, 224, 1'b1, 0);
    check_out("bnd_y", 1'b1, 0, 0, 0, 0, 0);
    run_pixel("bnd_in", 287, 223, 1'b1, 35 * 28 + 27);
    check_out("bnd_in", 1'b1, 1, 0, 0, 63, 0);

    // Bubbles and reset: valid 1,0,1 with reset while the third is in S1
    map_rdata = 8'd1;
    show_en   = 1'b1;
    pix_valid = 1'b1;
    x_cord    = 10'd9;
    y_cord    = 10'd17;
    tick();
    pix_valid = 1'b0;
    tick();
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    check_out("bub1", 1'b1, 1, 1, 0, 9, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("bub_rst", 1'b0, 0, 0, 0, 0, 0);
    check("bub_rst raddr", 32'(map_raddr), 0);
    tick();
    check("bub_drop1 valid", 32'(valid), 0);
    check("bub_drop1 sel",   32'(mem_select), 0);
    tick();
    check("bub_drop2 valid", 32'(valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
